// File: rtl/ensemble_pkg.sv
// Shared FSM states and result-field layout helpers for the ensemble vote engine.
package ensemble_pkg;

    typedef enum logic [1:0] {
        StCollect,
        StVote,
        StOutput
    } vote_state_e;

    localparam int unsigned LabelLsb = 0;

    // Width needed to hold a vote count of 0..n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    function automatic int unsigned count_lsb(input int unsigned class_width);
        return class_width;
    endfunction

    function automatic int unsigned unanimous_bit(input int unsigned class_width,
                                                  input int unsigned n);
        return class_width + cnt_width(n);
    endfunction

endpackage

// File: rtl/axis_broadcast_fork.sv
// Lossless 1-to-N AXI-Stream fork: each beat reaches every lane exactly once,
// tracked per lane so slow lanes never cause re-delivery to fast ones.
module axis_broadcast_fork #(
    parameter int unsigned NUM_LANES  = 3,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned KEEP_WIDTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [DATA_WIDTH-1:0]           s_tdata,
    input  logic [KEEP_WIDTH-1:0]           s_tkeep,
    input  logic                            s_tvalid,
    output logic                            s_tready,
    input  logic                            s_tlast,
    output logic [NUM_LANES*DATA_WIDTH-1:0] c_tdata,
    output logic [NUM_LANES*KEEP_WIDTH-1:0] c_tkeep,
    output logic [NUM_LANES-1:0]            c_tlast,
    output logic [NUM_LANES-1:0]            c_tvalid,
    input  logic [NUM_LANES-1:0]            c_tready
);

    logic [NUM_LANES-1:0] sent_q, sent_d;

    assign c_tdata  = {NUM_LANES{s_tdata}};
    assign c_tkeep  = {NUM_LANES{s_tkeep}};
    assign c_tlast  = {NUM_LANES{s_tlast}};
    assign c_tvalid = {NUM_LANES{s_tvalid}} & ~sent_q;
    assign s_tready = &(c_tready | sent_q);

    always_comb begin
        sent_d = sent_q | (c_tvalid & c_tready);
        if (s_tvalid && s_tready) begin
            sent_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sent_q <= '0;
        end else begin
            sent_q <= sent_d;
        end
    end

endmodule

// File: rtl/ensemble_vote_engine.sv
// N-way classifier ensemble: broadcasts features to every lane, gathers one label
// per lane and emits a sequential majority vote (ties go to the lowest lane).
module ensemble_vote_engine
    import ensemble_pkg::*;
#(
    parameter int unsigned NUM_CLASSIFIERS = 3,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned KEEP_WIDTH      = 4,
    parameter int unsigned CLASS_WIDTH     = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [DATA_WIDTH-1:0]                 s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]                 s_axis_tkeep,
    input  logic                                  s_axis_tvalid,
    output logic                                  s_axis_tready,
    input  logic                                  s_axis_tlast,
    output logic [NUM_CLASSIFIERS*DATA_WIDTH-1:0] c_axis_tdata,
    output logic [NUM_CLASSIFIERS*KEEP_WIDTH-1:0] c_axis_tkeep,
    output logic [NUM_CLASSIFIERS-1:0]            c_axis_tlast,
    output logic [NUM_CLASSIFIERS-1:0]            c_axis_tvalid,
    input  logic [NUM_CLASSIFIERS-1:0]            c_axis_tready,
    input  logic [NUM_CLASSIFIERS*DATA_WIDTH-1:0] r_axis_tdata,
    input  logic [NUM_CLASSIFIERS-1:0]            r_axis_tvalid,
    input  logic [NUM_CLASSIFIERS-1:0]            r_axis_tlast,
    output logic [NUM_CLASSIFIERS-1:0]            r_axis_tready,
    output logic [DATA_WIDTH-1:0]                 m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]                 m_axis_tkeep,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic                                  m_axis_tlast,
    output logic [31:0]                           disagree_cnt
);

    localparam int unsigned N    = NUM_CLASSIFIERS;
    localparam int unsigned CntW = cnt_width(N);
    localparam int unsigned IdxW = $clog2(N);

    vote_state_e            state_q, state_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [CntW-1:0]        best_cnt_q, best_cnt_d;
    logic [CLASS_WIDTH-1:0] best_label_q, best_label_d;
    logic [N-1:0]           hold_valid_q, hold_valid_d;
    logic [CLASS_WIDTH-1:0] label_q [N];
    logic [CLASS_WIDTH-1:0] label_d [N];
    logic [31:0]            disagree_cnt_q, disagree_cnt_d;
    logic [CntW-1:0]        match_cnt;
    logic                   unanimous;
    logic                   unused_rdata;

    axis_broadcast_fork #(
        .NUM_LANES  (N),
        .DATA_WIDTH (DATA_WIDTH),
        .KEEP_WIDTH (KEEP_WIDTH)
    ) u_fork (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tdata  (s_axis_tdata),
        .s_tkeep  (s_axis_tkeep),
        .s_tvalid (s_axis_tvalid),
        .s_tready (s_axis_tready),
        .s_tlast  (s_axis_tlast),
        .c_tdata  (c_axis_tdata),
        .c_tkeep  (c_axis_tkeep),
        .c_tlast  (c_axis_tlast),
        .c_tvalid (c_axis_tvalid),
        .c_tready (c_axis_tready)
    );

    // Only the label bits of each result beat carry meaning.
    assign unused_rdata  = ^r_axis_tdata;
    assign r_axis_tready = ~hold_valid_q;
    assign unanimous     = (best_cnt_q == CntW'(N));
    assign disagree_cnt  = disagree_cnt_q;
    assign m_axis_tkeep  = '1;
    assign m_axis_tlast  = 1'b1;

    always_comb begin
        match_cnt = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (label_q[i] == label_q[idx_q]) begin
                match_cnt = match_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        m_axis_tdata = '0;
        m_axis_tdata[LabelLsb +: CLASS_WIDTH]         = best_label_q;
        m_axis_tdata[count_lsb(CLASS_WIDTH) +: CntW]  = best_cnt_q;
        m_axis_tdata[unanimous_bit(CLASS_WIDTH, N)]   = unanimous;
    end

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        best_cnt_d     = best_cnt_q;
        best_label_d   = best_label_q;
        hold_valid_d   = hold_valid_q;
        label_d        = label_q;
        disagree_cnt_d = disagree_cnt_q;
        m_axis_tvalid  = 1'b0;

        // Non-last beats are consumed and dropped; the last beat carries the label.
        for (int unsigned i = 0; i < N; i++) begin
            if (r_axis_tvalid[i] && !hold_valid_q[i] && r_axis_tlast[i]) begin
                label_d[i]      = r_axis_tdata[i*DATA_WIDTH +: CLASS_WIDTH];
                hold_valid_d[i] = 1'b1;
            end
        end

        unique case (state_q)
            StCollect: begin
                if (&hold_valid_q) begin
                    state_d    = StVote;
                    idx_d      = '0;
                    best_cnt_d = '0;
                end
            end
            StVote: begin
                if (match_cnt > best_cnt_q) begin
                    best_cnt_d   = match_cnt;
                    best_label_d = label_q[idx_q];
                end
                if (idx_q == IdxW'(N - 1)) begin
                    state_d = StOutput;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StOutput: begin
                m_axis_tvalid = 1'b1;
                if (m_axis_tready) begin
                    hold_valid_d = '0;
                    state_d      = StCollect;
                    if (!unanimous && (disagree_cnt_q != '1)) begin
                        disagree_cnt_d = disagree_cnt_q + 32'd1;
                    end
                end
            end
            default: state_d = StCollect;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StCollect;
            idx_q          <= '0;
            best_cnt_q     <= '0;
            best_label_q   <= '0;
            hold_valid_q   <= '0;
            disagree_cnt_q <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                label_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            best_cnt_q     <= best_cnt_d;
            best_label_q   <= best_label_d;
            hold_valid_q   <= hold_valid_d;
            disagree_cnt_q <= disagree_cnt_d;
            label_q        <= label_d;
        end
    end

endmodule

// File: doc/ensemble_vote_engine.md
Name: ensemble_vote_engine

Overview:
Parametrised N-way ensemble front/back end for the HLS classifier cores (gradient_boost, logistic_regression, mlp, ...). Broadcasts one AXI-Stream feature stream to NUM_CLASSIFIERS classifier lanes with a lossless fork handshake. Collects one result per lane per sample and runs a sequential majority vote. Emits a single voted AXI-Stream result beat per sample.

Parameters:
NUM_CLASSIFIERS, 3, number of classifier lanes (2..8)
DATA_WIDTH, 32, AXI-Stream tdata width, all interfaces
KEEP_WIDTH, 4, tkeep width (DATA_WIDTH/8)
CLASS_WIDTH, 8, class label width, taken from result tdata[CLASS_WIDTH-1:0]

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_axis_tdata/tkeep/tvalid/tready/tlast  in/in/in/out/in  DATA_WIDTH/KEEP_WIDTH/1/1/1  feature input stream
c_axis_tdata/tkeep/tlast  out  N*DATA_WIDTH/N*KEEP_WIDTH/N  per-lane feature copies to classifiers, lane i at slice i
c_axis_tvalid  out  N  per-lane valid
c_axis_tready  in  N  per-lane ready
r_axis_tdata  in  N*DATA_WIDTH  per-lane classifier results
r_axis_tvalid/tlast  in  N/N  per-lane result valid/last
r_axis_tready  out  N  per-lane result ready
m_axis_tdata/tkeep/tvalid/tready/tlast  out/out/out/in/out  DATA_WIDTH/KEEP_WIDTH/1/1/1  voted result
disagree_cnt  out  32  saturating count of non-unanimous votes

Behaviour:
- Reset (async, rst_n=0): sent[], hold_valid[], m_axis_tvalid, disagree_cnt, FSM state, vote index/best registers all cleared; state=COLLECT. Outputs low immediately, including mid-vote.
- Broadcast fork: c_axis_tdata/tkeep/tlast[i] = s_axis copies. c_axis_tvalid[i] = s_axis_tvalid & ~sent[i]. s_axis_tready = AND over i of (c_axis_tready[i] | sent[i]). sent[i] set on a lane handshake without full completion; all sent[] clear when s_axis handshake completes. Each beat is delivered exactly once per lane. No bubble when all lanes ready. Fork is independent of the vote FSM.
- Result capture: one hold register per lane (label + hold_valid). r_axis_tready[i] = ~hold_valid[i]. Beats with tlast=0 are accepted and discarded. Beat with tlast=1 latches tdata[CLASS_WIDTH-1:0] and sets hold_valid[i].
- FSM COLLECT: wait until all hold_valid=1 -> VOTE, idx=0, best_cnt=0.
- FSM VOTE: one lane per cycle. cnt = number of lanes whose label equals label[idx], width CNT_W=$clog2(N+1). If cnt > best_cnt (strictly greater), then best_label=label[idx] and best_cnt=cnt. Ties resolve to the lowest-index lane. After idx=N-1 -> OUTPUT. Duration is N cycles.
- FSM OUTPUT: m_axis_tvalid=1. m_axis_tdata = {zeros, unanimous, best_cnt, best_label}: label in [CLASS_WIDTH-1:0], count in [CLASS_WIDTH +: CNT_W], unanimous (best_cnt==N) in the next bit above. m_axis_tkeep = all ones, m_axis_tlast = 1. Data stable while tvalid & ~tready. On handshake: clear all hold_valid, increment disagree_cnt if not unanimous (saturates at 2^32-1), -> COLLECT.
- Latency: last hold_valid set at cycle t -> m_axis_tvalid at t+N+1.
- During VOTE/OUTPUT, filled lanes backpressure (tready=0). Lanes cannot be empty in these states.
- Simultaneous: a result arriving in the same cycle as the OUTPUT handshake is not accepted (tready low that cycle); it is accepted next cycle.

Decomposition:
- Package ensemble_pkg: state enum (COLLECT, VOTE, OUTPUT), CNT_W function, result field offset constants.
- Sub-module axis_broadcast_fork: sent[] tracking and fork handshake, parametrised by N and width.

Test Plan:
- N=3, results 5,5,2 -> m_tdata label=5, count=2, unanimous=0; tvalid 4 cycles after last result; disagree_cnt=1.
- Results 7,7,7 -> label=7, count=3, unanimous=1; disagree_cnt unchanged.
- Tie 1,2,3 -> label=1, count=1 (lane 0 wins).
- Lane 1 c_tready low 3 cycles -> lanes 0/2 receive the beat exactly once; s_tready low until lane 1 takes it; no duplicates.
- m_tready low 5 cycles; lane 0 sends a second result -> m_tdata stable; r_tready[0]=0 until handshake; second sample voted correctly afterwards.
- rst_n asserted in VOTE -> m_tvalid=0, r_tready all 1, disagree_cnt=0 immediately; next sample votes correctly.
